top_pipelined: RTL and testbench

- Parametrised successor to the basic two-node top. It accepts operand triples (a, b, c) over a valid/ready handshake and computes a mode-selected arithmetic result plus a logic result.
- Results travel through a DEPTH-deep elastic register pipeline and leave on a valid/ready output, with an overflow flag and a completed-transfer counter.
- Sits at top level between the stimulus source and downstream consumers.
- Replaces the fixed-latency, no-backpressure datapath.

---
 rtl/top_pipelined_pkg.sv | 23 ++
 rtl/top_pipelined_pipe_stage.sv | 23 ++
 rtl/top_pipelined.sv | 58 +++++
 tb/tb_top_pipelined.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/top_pipelined_pkg.sv
// top_pipelined_pkg: operation modes and the shared arithmetic helper for top_pipelined
package top_pipelined_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {
    MODE_ADD_WRAP = 2'd0,
    MODE_ADD_SAT  = 2'd1,
    MODE_SUB_SAT  = 2'd2,
    MODE_LOGIC    = 2'd3
  } mode_e;
  function automatic logic [MAX_W:0] compute_x(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                               input mode_e mode, input int w);
    logic [MAX_W:0] sum;
    logic [MAX_W:0] mask;
    logic c;
    sum = {1'b0, a} + {1'b0, b};
    mask = ~({(MAX_W+1){1'b1}} << w);
    c = (sum >> w) != '0;
    return mode == MODE_ADD_WRAP ? {c, sum[MAX_W-1:0] & mask[MAX_W-1:0]} :
           mode == MODE_ADD_SAT  ? {c, c ? mask[MAX_W-1:0] : sum[MAX_W-1:0]} :
           mode == MODE_SUB_SAT  ? {a < b, a < b ? {MAX_W{1'b0}} : a - b} :
                                   {1'b0, a & b};
  endfunction
endpackage

// File: rtl/top_pipelined_pipe_stage.sv
// pipe_stage: one elastic register slice with valid/ready on both sides
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
endmodule

// File: rtl/top_pipelined.sv
// top_pipelined: mode-selected arithmetic/logic on (a,b,c) through a DEPTH-deep elastic pipeline
module top_pipelined
  import top_pipelined_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [WIDTH-1:0] input_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_x,
  output logic [WIDTH-1:0] output_y,
  output logic             output_ovf,
  output logic [CNT_W-1:0] xfer_count
);
  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             ovf;
  } payload_t;
  localparam int PW = $bits(payload_t);
  logic [MAX_W:0] r;
  logic           unused_hi;
  logic           v   [DEPTH+1];
  logic           rdy [DEPTH+1];
  payload_t       d   [DEPTH+1];
  assign r         = compute_x(MAX_W'(input_a), MAX_W'(input_b), mode_e'(in_mode), WIDTH);
  assign unused_hi = ^r[MAX_W-1:WIDTH];
  assign d[0]      = '{x: r[WIDTH-1:0], y: (input_a ^ input_c) | input_b, ovf: r[MAX_W]};
  assign v[0]      = in_valid;
  assign in_ready  = rdy[0];
  assign rdy[DEPTH] = out_ready;
  assign out_valid = v[DEPTH];
  assign {output_x, output_y, output_ovf} = d[DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(.W(PW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (v[i]),
      .in_ready (rdy[i]),
      .in_data  (d[i]),
      .out_valid(v[i+1]),
      .out_ready(rdy[i+1]),
      .out_data (d[i+1])
    );
  end
  always_ff @(posedge clk)
    if (rst) xfer_count <= '0;
    else if (out_valid && out_ready) xfer_count <= xfer_count + CNT_W'(1);
endmodule

// File: tb/tb_top_pipelined.sv
// tb_top_pipelined: randomized and directed checks of top_pipelined against a queue-level model
module tb_top_pipelined;
  localparam int W  = 8;
  localparam int D  = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_mode = '0;
  logic [W-1:0]  input_a = '0, input_b = '0, input_c = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  output_x, output_y;
  logic          output_ovf;
  logic [CW-1:0] xfer_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int x;
    int y;
    int ovf;
    int acc;
  } item_t;
  item_t q[$];
  item_t it;
  int    cyc = 0, last_pop = -1000, exp_cnt = 0, r;
  bit    ev, er;

  always #5 clk = ~clk;

  top_pipelined #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .input_a   (input_a),
    .input_b   (input_b),
    .input_c   (input_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .output_x  (output_x),
    .output_y  (output_y),
    .output_ovf(output_ovf),
    .xfer_count(xfer_count)
  );

  // returns ovf*65536 + x
  function automatic int model_x(int a, int b, int m);
    int s, lim;
    s = a + b;
    lim = 1 << W;
    if (m == 0) return (s >= lim ? 65536 : 0) + s % lim;
    if (m == 1) return s >= lim ? 65536 + lim - 1 : s;
    if (m == 2) return a < b ? 65536 : a - b;
    return a & b;
  endfunction

  function automatic int model_y(int a, int b, int c);
    return (a ^ c) | b;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // Item i shows at the output once it has spent DEPTH cycles inside and its predecessor has left.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt  = 0;
      last_pop = -1000;
    end else begin
      ev = 1'b0;
      if (q.size() > 0) ev = cyc >= q[0].acc + D && cyc > last_pop;
      er = !(q.size() == D && !out_ready);
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("in_ready", 32'(in_ready), 32'(er));
      chk("xfer_count", 32'(xfer_count), exp_cnt);
      if (ev) begin
        chk("output_x", 32'(output_x), q[0].x);
        chk("output_y", 32'(output_y), q[0].y);
        chk("output_ovf", 32'(output_ovf), q[0].ovf);
        if (out_ready) begin
          void'(q.pop_front());
          last_pop = cyc;
          exp_cnt  = (exp_cnt + 1) % (1 << CW);
        end
      end
      if (in_valid && er) begin
        r      = model_x(int'(input_a), int'(input_b), int'(in_mode));
        it.x   = r % 65536;
        it.ovf = r / 65536;
        it.y   = model_y(int'(input_a), int'(input_b), int'(input_c));
        it.acc = cyc;
        q.push_back(it);
      end
    end
    cyc++;
  end

  task automatic rnd_in();
    input_a = W'($urandom);
    input_b = W'($urandom);
    input_c = W'($urandom);
    in_mode = 2'($urandom);
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [1:0] m);
    int g;
    g = 0;
    input_a  = a;
    input_b  = b;
    input_c  = c;
    in_mode  = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      g++;
      @(negedge clk);
    end
    chk("push_accept", 32'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, acc, g;
    bit hs;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_x", 32'(output_x), 0);
    chk("rst_y", 32'(output_y), 0);
    chk("rst_ovf", 32'(output_ovf), 0);
    chk("rst_cnt", 32'(xfer_count), 0);
    chk("model_wrap", model_x('hF0, 'h20, 0), 'h10010);
    chk("model_y", model_y('hF0, 'h20, 'h0F), 'hFF);
    chk("model_sat", model_x('hF0, 'h20, 1), 'h100FF);
    chk("model_sub_neg", model_x('h05, 'h09, 2), 'h10000);
    chk("model_sub_pos", model_x('h09, 'h05, 2), 'h04);
    chk("model_logic", model_x('hCC, 'hAA, 3), 'h88);

    @(posedge clk);
    #1 out_ready = 1'b1;
    input_a = 8'hF0; input_b = 8'h20; input_c = 8'h0F; in_mode = 2'd0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, 3);
    chk("lat_x", 32'(output_x), 'h10);
    chk("lat_y", 32'(output_y), 'hFF);
    chk("lat_ovf", 32'(output_ovf), 1);

    @(posedge clk);
    #1;
    push(8'hF0, 8'h20, 8'h0F, 2'd1);
    push(8'h05, 8'h09, 8'h00, 2'd2);
    push(8'h09, 8'h05, 8'h00, 2'd2);
    push(8'hCC, 8'hAA, 8'h00, 2'd3);
    for (int i = 0; i < 10; i++) push(W'($urandom), W'($urandom), W'($urandom), 2'($urandom));
    repeat (6) @(posedge clk);

    #1 out_ready = 1'b0;
    in_valid = 1'b1;
    rnd_in();
    acc = 0;
    repeat (6) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1 if (hs) begin
        acc++;
        rnd_in();
      end
    end
    chk("bp_accepted", acc, 3);
    @(negedge clk);
    chk("bp_stall_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    g = 0;
    while (acc < 5 && g < 20) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1 g++;
      if (hs) begin
        acc++;
        if (acc < 5) rnd_in();
      end
    end
    in_valid = 1'b0;
    chk("bp_total", acc, 5);
    repeat (6) @(posedge clk);

    repeat (400) begin
      #1 out_ready = ($urandom % 3) != 0;
      in_valid = ($urandom % 4) != 0;
      rnd_in();
      @(posedge clk);
    end

    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 out_ready = 1'b0;
    push(8'h11, 8'h22, 8'h33, 2'd0);
    push(8'h44, 8'h55, 8'h66, 2'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_cnt", 32'(xfer_count), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    repeat (6) @(posedge clk);

    #1;
    for (int i = 0; i < 17; i++) push(W'($urandom), W'($urandom), W'($urandom), 2'($urandom));
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("wrap_cnt", 32'(xfer_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
